// File: rtl/symm_mat_load.sv
// Stream-to-matrix loader: buffers 16 row-major elements in a shadow bank and
// commits them atomically to registered 4x4 outputs on a well-framed last element.
module symm_mat_load #(
   parameter int W = 26
) (
   input  logic                clk_ld,
   input  logic                rstn_ld,
   input  logic                clr_ld,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic signed [W-1:0] in_data,
   input  logic                in_last,
   output logic signed [W-1:0] o11,
   output logic signed [W-1:0] o12,
   output logic signed [W-1:0] o13,
   output logic signed [W-1:0] o14,
   output logic signed [W-1:0] o21,
   output logic signed [W-1:0] o22,
   output logic signed [W-1:0] o23,
   output logic signed [W-1:0] o24,
   output logic signed [W-1:0] o31,
   output logic signed [W-1:0] o32,
   output logic signed [W-1:0] o33,
   output logic signed [W-1:0] o34,
   output logic signed [W-1:0] o41,
   output logic signed [W-1:0] o42,
   output logic signed [W-1:0] o43,
   output logic signed [W-1:0] o44,
   output logic                mat_valid,
   output logic                err_frame,
   output logic [7:0]          mat_cnt
);

   localparam int N_SH  = 15;
   localparam int N_MAT = 16;

   logic [3:0]          idx_r;
   logic [3:0]          idx_nxt_s;
   logic signed [W-1:0] shadow_r [N_SH];
   logic signed [W-1:0] mat_r    [N_MAT];
   logic                rdy_pre_r;
   logic                rdy_r;
   logic                mat_valid_r;
   logic                err_frame_r;
   logic [7:0]          mat_cnt_r;
   logic                acc_s;
   logic                commit_s;
   logic                err_s;
   logic                wr_s;

   assign acc_s = in_valid && rdy_r;

   // Frame decode: clear wins over accept; last on the 16th slot commits, any other last/no-last mismatch drops the frame
   always_comb begin
      idx_nxt_s = idx_r;
      commit_s  = 1'b0;
      err_s     = 1'b0;
      wr_s      = 1'b0;
      if (clr_ld) begin
         idx_nxt_s = 4'd0;
      end else if (acc_s) begin
         if (idx_r == 4'd15) begin
            idx_nxt_s = 4'd0;
            if (in_last) begin
               commit_s = 1'b1;
            end else begin
               err_s = 1'b1;
            end
         end else if (in_last) begin
            idx_nxt_s = 4'd0;
            err_s     = 1'b1;
         end else begin
            wr_s      = 1'b1;
            idx_nxt_s = idx_r + 4'd1;
         end
      end else begin
         idx_nxt_s = idx_r;
      end
   end

   // Control state: element index, ready ramp-up, status pulses and commit counter
   always_ff @(posedge clk_ld or negedge rstn_ld) begin
      if (!rstn_ld) begin
         idx_r       <= 4'd0;
         rdy_pre_r   <= 1'b0;
         rdy_r       <= 1'b0;
         mat_valid_r <= 1'b0;
         err_frame_r <= 1'b0;
         mat_cnt_r   <= 8'd0;
      end else begin
         idx_r       <= idx_nxt_s;
         rdy_pre_r   <= 1'b1;
         rdy_r       <= rdy_pre_r;
         mat_valid_r <= commit_s;
         err_frame_r <= err_s;
         mat_cnt_r   <= commit_s ? mat_cnt_r + 8'd1 : mat_cnt_r;
      end
   end

   // Shadow bank: one slot written per accepted non-final element
   always_ff @(posedge clk_ld or negedge rstn_ld) begin
      if (!rstn_ld) begin
         for (int i = 0; i < N_SH; i++) begin
            shadow_r[i] <= {W{1'b0}};
         end
      end else begin
         for (int i = 0; i < N_SH; i++) begin
            if (wr_s && (idx_r == 4'(i))) begin
               shadow_r[i] <= in_data;
            end else begin
               shadow_r[i] <= shadow_r[i];
            end
         end
      end
   end

   // Committed matrix: all 16 elements replaced on the same edge so no mix is ever visible
   always_ff @(posedge clk_ld or negedge rstn_ld) begin
      if (!rstn_ld) begin
         for (int i = 0; i < N_MAT; i++) begin
            mat_r[i] <= {W{1'b0}};
         end
      end else if (commit_s) begin
         for (int i = 0; i < N_SH; i++) begin
            mat_r[i] <= shadow_r[i];
         end
         mat_r[15] <= in_data;
      end else begin
         for (int i = 0; i < N_MAT; i++) begin
            mat_r[i] <= mat_r[i];
         end
      end
   end

   assign in_ready  = rdy_r;
   assign mat_valid = mat_valid_r;
   assign err_frame = err_frame_r;
   assign mat_cnt   = mat_cnt_r;

   assign o11 = mat_r[0];
   assign o12 = mat_r[1];
   assign o13 = mat_r[2];
   assign o14 = mat_r[3];
   assign o21 = mat_r[4];
   assign o22 = mat_r[5];
   assign o23 = mat_r[6];
   assign o24 = mat_r[7];
   assign o31 = mat_r[8];
   assign o32 = mat_r[9];
   assign o33 = mat_r[10];
   assign o34 = mat_r[11];
   assign o41 = mat_r[12];
   assign o42 = mat_r[13];
   assign o43 = mat_r[14];
   assign o44 = mat_r[15];

endmodule

// File: tb/tb_symm_mat_load.sv
// Scoreboard bench for symm_mat_load: a frame model pushes expected commits/errors,
// a per-cycle monitor pops them and checks pulses, counter and the held matrix.
module tb_symm_mat_load;

   localparam int W  = 26;
   localparam int MW = 16 * W;

   typedef struct {
      logic          err;
      logic [MW-1:0] m;
      logic [7:0]    cnt;
   } exp_t;

   logic                clk_ld;
   logic                rstn_ld;
   logic                clr_ld;
   logic                in_valid;
   logic                in_ready;
   logic signed [W-1:0] in_data;
   logic                in_last;
   logic signed [W-1:0] o11, o12, o13, o14, o21, o22, o23, o24;
   logic signed [W-1:0] o31, o32, o33, o34, o41, o42, o43, o44;
   logic                mat_valid;
   logic                err_frame;
   logic [7:0]          mat_cnt;
   logic [MW-1:0]       out_vec;

   int            n_tests;
   int            n_fail;
   exp_t          exp_q[$];
   exp_t          mon_e;
   logic [MW-1:0] vis;
   logic [3:0]    m_idx;
   logic [W-1:0]  m_sh [15];
   logic [7:0]    m_cnt;

   symm_mat_load #(.W(W)) dut (
      .clk_ld(clk_ld), .rstn_ld(rstn_ld), .clr_ld(clr_ld),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .o11(o11), .o12(o12), .o13(o13), .o14(o14),
      .o21(o21), .o22(o22), .o23(o23), .o24(o24),
      .o31(o31), .o32(o32), .o33(o33), .o34(o34),
      .o41(o41), .o42(o42), .o43(o43), .o44(o44),
      .mat_valid(mat_valid), .err_frame(err_frame), .mat_cnt(mat_cnt)
   );

   assign out_vec = {o11, o12, o13, o14, o21, o22, o23, o24,
                     o31, o32, o33, o34, o41, o42, o43, o44};

   initial begin
      clk_ld = 1'b0;
      forever #5 clk_ld = ~clk_ld;
   end

   task automatic check_eq(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_idx = 4'd0;
      m_cnt = 8'd0;
      for (int i = 0; i < 15; i++) m_sh[i] = '0;
   endtask

   // one accepted element; the frame model updates right at the accepting edge
   task automatic send(input logic [W-1:0] d, input logic last);
      exp_t e;
      @(negedge clk_ld);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      check_eq("ready", in_ready, 1'b1);
      @(posedge clk_ld);
      if (m_idx == 4'd15) begin
         m_idx = 4'd0;
         if (last) begin
            for (int k = 0; k < 15; k++) e.m[(15-k)*W +: W] = m_sh[k];
            e.m[W-1:0] = d;
            m_cnt = m_cnt + 8'd1;
            e.err = 1'b0;
         end else begin
            e.m   = '0;
            e.err = 1'b1;
         end
         e.cnt = m_cnt;
         exp_q.push_back(e);
      end else if (last) begin
         m_idx = 4'd0;
         e.err = 1'b1;
         e.m   = '0;
         e.cnt = m_cnt;
         exp_q.push_back(e);
      end else begin
         m_sh[m_idx] = d;
         m_idx = m_idx + 4'd1;
      end
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // idle cycles with junk on data/last that must not be sampled
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk_ld);
         in_valid = 1'b0;
         in_data  = W'($urandom);
         in_last  = 1'($urandom);
      end
   endtask

   task automatic frame_seq(input int start, input int step, input bit gaps);
      for (int k = 0; k < 16; k++) begin
         send(W'(start + step * k), k == 15);
         if (gaps) idle($urandom_range(0, 2));
      end
   endtask

   task automatic frame_rand();
      for (int k = 0; k < 16; k++) send(W'($urandom), k == 15);
   endtask

   // monitor: every cycle the pulses, counter and visible matrix must match the scoreboard
   initial begin
      vis = '0;
      forever begin
         @(posedge clk_ld);
         #1;
         if (!rstn_ld) begin
            vis = '0;
            exp_q.delete();
         end else begin
            if (exp_q.size() > 0) begin
               mon_e = exp_q.pop_front();
               check_eq("mat_valid", mat_valid, !mon_e.err);
               check_eq("err_frame", err_frame, mon_e.err);
               if (!mon_e.err) vis = mon_e.m;
               check_eq("mat_cnt", mat_cnt, mon_e.cnt);
            end else begin
               check_eq("mat_valid_idle", mat_valid, 1'b0);
               check_eq("err_frame_idle", err_frame, 1'b0);
            end
            check_eq("matrix", out_vec, vis);
         end
      end
   end

   initial begin
      n_tests  = 0;
      n_fail   = 0;
      rstn_ld  = 1'b0;
      clr_ld   = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      in_last  = 1'b0;
      model_reset();

      #22;
      check_eq("rst_matrix", out_vec, '0);
      check_eq("rst_valid", mat_valid, 1'b0);
      check_eq("rst_err", err_frame, 1'b0);
      check_eq("rst_cnt", mat_cnt, 8'd0);
      check_eq("rst_ready", in_ready, 1'b0);
      @(negedge clk_ld);
      rstn_ld = 1'b1;
      @(posedge clk_ld); #1;
      check_eq("ready_edge1", in_ready, 1'b0);
      @(posedge clk_ld); #1;
      check_eq("ready_edge2", in_ready, 1'b1);

      // single frame 1..16
      frame_seq(1, 1, 1'b0);
      check_eq("o11_seq", $unsigned(o11), W'(1));
      check_eq("o14_seq", $unsigned(o14), W'(4));
      check_eq("o21_seq", $unsigned(o21), W'(5));
      check_eq("o44_seq", $unsigned(o44), W'(16));
      check_eq("cnt_seq", mat_cnt, 8'd1);
      idle(3);

      // negatives with random gaps
      frame_seq(-1, -1, 1'b1);
      idle(2);
      check_eq("o11_neg", $unsigned(o11), 26'h3FFFFFF);
      check_eq("o44_neg", $unsigned(o44), 26'h3FFFFF0);

      // back-to-back frames
      frame_rand();
      frame_rand();
      idle(2);

      // early last on element 5, then a good frame
      for (int k = 0; k < 5; k++) send(W'(100 + k), k == 4);
      idle(2);
      check_eq("cnt_after_early", mat_cnt, 8'd4);
      frame_seq(200, 3, 1'b0);
      idle(2);

      // 16 elements without last, then a good frame
      for (int k = 0; k < 16; k++) send(W'(300 + k), 1'b0);
      idle(2);
      check_eq("cnt_after_missing", mat_cnt, 8'd5);
      frame_seq(400, 7, 1'b0);
      idle(2);

      // clear after 10 elements with a discarded same-cycle accept
      for (int k = 0; k < 10; k++) send(W'(500 + k), 1'b0);
      @(negedge clk_ld);
      clr_ld   = 1'b1;
      in_valid = 1'b1;
      in_data  = W'($urandom);
      in_last  = 1'b1;
      @(posedge clk_ld);
      m_idx = 4'd0;
      #1;
      clr_ld   = 1'b0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      frame_seq(600, -5, 1'b1);
      idle(2);
      check_eq("cnt_after_clear", mat_cnt, 8'd7);

      // reset mid-frame: outputs clear asynchronously
      for (int k = 0; k < 7; k++) send(W'(700 + k), 1'b0);
      @(negedge clk_ld);
      rstn_ld = 1'b0;
      #1;
      check_eq("mid_rst_matrix", out_vec, '0);
      check_eq("mid_rst_cnt", mat_cnt, 8'd0);
      check_eq("mid_rst_ready", in_ready, 1'b0);
      model_reset();
      repeat (2) @(posedge clk_ld);
      @(negedge clk_ld);
      rstn_ld = 1'b1;
      @(posedge clk_ld); #1;
      check_eq("mid_ready_edge1", in_ready, 1'b0);
      @(posedge clk_ld); #1;
      check_eq("mid_ready_edge2", in_ready, 1'b1);

      // counter wrap over 256 full-rate frames
      for (int f = 0; f < 256; f++) frame_rand();
      idle(3);
      check_eq("cnt_wrap", mat_cnt, 8'd0);
      check_eq("sb_drain", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/symm_mat_load.md
# symm_mat_load

Stream-to-matrix loader for the symmetric decorrelation datapath. It accepts 4x4 matrix elements one at a time over a valid/ready stream and buffers them in a shadow bank. On receipt of a complete, well-framed matrix it commits all 16 elements at once to parallel registered outputs and pulses `mat_valid`. Those outputs feed the `i1_*` / `i2_*` operand buses of the matrix subtract stage, and `mat_valid` drives that stage's enable.

## Interface
- `W`, default 26: element width, signed two's complement.
- `clk_ld` in 1: clock; all state updates on its rising edge.
- `rstn_ld` in 1: asynchronous active-low reset.
- `clr_ld` in 1: synchronous clear of a partial matrix; committed outputs are kept.
- `in_valid` in 1: stream element valid.
- `in_ready` out 1: loader can accept an element.
- `in_data` in W: signed element; elements arrive in row-major order (11, 12, 13, 14, 21, …, 44).
- `in_last` in 1: marks the 16th element of a matrix.
- `o11` … `o44` out W each, 16 ports: committed matrix, registered, signed.
- `mat_valid` out 1: one-cycle pulse; the outputs changed this cycle.
- `err_frame` out 1: one-cycle pulse; a framing error was detected and the partial matrix was dropped.
- `mat_cnt` out 8: number of committed matrices, wraps 255→0.

## Operation
- **Accept rule:** an element is accepted on a clock edge where `in_valid && in_ready`. `in_data` and `in_last` are sampled only on accepted edges.
- **Element counter `idx`** (4 bits, 0..15):
  - Selects the destination: row `idx[3:2]+1`, column `idx[1:0]+1`.
  - An accept with `idx<15` writes `in_data` to `shadow[idx]` and increments `idx`.
- **Commit:** an accept with `idx==15 && in_last==1` does all of the following on the same edge:
  - loads `o*` from `shadow[0..14]` plus `in_data` as `o44`;
  - sets `mat_valid` for one cycle;
  - increments `mat_cnt`;
  - sets `idx` to 0.
- **Early last:** an accept with `idx<15 && in_last==1` does not write the element. It pulses `err_frame`, sets `idx` to 0, and leaves `o*` unchanged.
- **Missing last:** an accept with `idx==15 && in_last==0` pulses `err_frame`, sets `idx` to 0, drops the element, and leaves `o*` unchanged.
- **Clear:** `clr_ld==1` sets `idx` to 0 and takes priority over a same-cycle accept, which is discarded. It produces no `err_frame`, and `o*`, `mat_cnt` and `shadow` contents are not cleared.
- **Shadow contents:** stale shadow entries are never visible, because a commit always follows 15 fresh writes in the current frame.
- **Output hold:** `o*` hold their value between commits regardless of stream activity. A downstream block may sample them at any time after `mat_valid`.
- **Ready:** `in_ready` is 0 during reset and on the first edge after release. It is 1 thereafter and never deasserts, so there is no backpressure.
- **Arithmetic:** data is passed bit-exact with no rounding or saturation. `mat_cnt` wraps modulo 256.

## Timing
- **Reset values:** all `o*` = 0, `shadow` = 0, `idx` = 0, `mat_valid` = 0, `err_frame` = 0, `mat_cnt` = 0, `in_ready` = 0.
- **Reset mid-frame:** the partial matrix is lost and outputs return to 0.
- **Commit latency:** `o*` and `mat_valid` are visible in the cycle following the accepting edge of element 16.
- **Throughput:**
  - Full rate is 16 cycles per matrix with back-to-back frames.
  - Element 1 of frame N+1 may be accepted on the edge right after the commit edge of frame N.
  - `mat_valid` can therefore pulse every 16 cycles.
- **Pulse width:** `err_frame` and `mat_valid` are registered, each exactly one cycle wide, and mutually exclusive.
- **Idle cycles:** idle cycles (`in_valid=0`) inside a frame are allowed and do not change `idx`.
- **Downstream handshake:** the subtract stage registers on its enable. Feeding it `mat_valid` yields a difference one cycle after the commit.

## Test plan
- **Single frame:**
  - Stimulus: reset, then stream values 1..16 with `in_last` on the 16th.
  - Required response: `o11`=1, `o14`=4, `o21`=5, `o44`=16; `mat_valid` is high for exactly one cycle, one cycle after the 16th accept; `mat_cnt`=1.
- **Negatives and gaps:**
  - Stimulus: stream -1, -2, …, -16 with random `in_valid` gaps.
  - Required response: `o11`=0x3FFFFFF, `o44`=-16 (26-bit); no `err_frame`; the previous outputs hold until the commit edge.
- **Back-to-back frames:**
  - Stimulus: 32 consecutive accepts forming two frames.
  - Required response: `mat_valid` pulses 16 cycles apart; the second matrix replaces the first atomically, so no mix of elements is ever visible.
- **Framing errors:**
  - Stimulus: `in_last` on the 5th element.
  - Required response: `err_frame` pulses once; `o*` and `mat_cnt` are unchanged; the next 16 well-framed elements commit correctly.
  - Stimulus: repeat with 16 elements and no `in_last`.
  - Required response: same as above.
- **Clear and reset:**
  - Stimulus: `clr_ld` after 10 elements, then a full frame.
  - Required response: a correct commit with no error.
  - Stimulus: assert `rstn_ld` low mid-frame.
  - Required response: all outputs go to 0 immediately (asynchronously); `in_ready` returns to 1 on the second edge after release.
- **Counter wrap:**
  - Stimulus: 256 frames.
  - Required response: `mat_cnt` returns to 0.
